// File: rtl/aes_pkg.sv
// Shared AES decryption constants and GF(2^8) helpers.
// All multiplies are built from xtime chains, so no lookup ROM is needed.
package aes_pkg;

    localparam int NB      = 4;
    localparam int STATE_W = NB * 32;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] r;
        r = {b[6:0], 1'b0};
        if (b[7]) begin
            r = r ^ 8'h1b;
        end else begin
            r = r;
        end
        return r;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Bit offset of the byte at (column, row); row 0 is the least significant byte of a column
    function automatic int byte_lsb(input int col, input int row);
        return 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column.
// Row r of the column occupies bits [r*8+7:r*8].
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a_s [4];

    // Split the column into its four row bytes
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a_s[r] = col_in[byte_lsb(0, r) +: 8];
        end
    end

    // Circulant matrix {0e,0b,0d,09}, rotated one position per row
    always_comb begin
        col_out[7:0]   = gmul14(a_s[0]) ^ gmul11(a_s[1]) ^ gmul13(a_s[2]) ^ gmul9(a_s[3]);
        col_out[15:8]  = gmul9(a_s[0])  ^ gmul14(a_s[1]) ^ gmul11(a_s[2]) ^ gmul13(a_s[3]);
        col_out[23:16] = gmul13(a_s[0]) ^ gmul9(a_s[1])  ^ gmul14(a_s[2]) ^ gmul11(a_s[3]);
        col_out[31:24] = gmul11(a_s[0]) ^ gmul13(a_s[1]) ^ gmul9(a_s[2])  ^ gmul14(a_s[3]);
    end

endmodule

// File: rtl/inv_addkey_mixcol.sv
// Two-stage AddRoundKey -> InvMixColumns pipeline with valid/ready flow control.
// S1 holds the key-mixed state, S2 holds the round result driven onto the outputs.
module inv_addkey_mixcol
    import aes_pkg::*;
#(
    parameter int NWords = NB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NWords*32-1:0]  state_in,
    input  logic [NWords*32-1:0]  round_key,
    input  logic                  last_round,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NWords*32-1:0]  state_out,
    output logic                  out_last
);

    localparam int W = NWords * 32;

    logic         v1_r, v2_r, last1_r, last2_r;
    logic [W-1:0] d1_r, d2_r, mix_cols_s, mixed_s;
    logic         s1_free_s, s2_free_s, load1_s, load2_s;

    // Flow control; in_ready never looks at in_valid to avoid a comb loop upstream
    always_comb begin
        s2_free_s = !v2_r || out_ready;
        s1_free_s = !v1_r || s2_free_s;
        load1_s   = in_valid && s1_free_s;
        load2_s   = v1_r && s2_free_s;
    end

    assign in_ready  = s1_free_s;
    assign state_out = d2_r;
    assign out_valid = v2_r;
    assign out_last  = last2_r;

    for (genvar c = 0; c < NWords; c++) begin : g_col
        inv_mix_column u_col (
            .col_in  (d1_r[c*32 +: 32]),
            .col_out (mix_cols_s[c*32 +: 32])
        );
    end

    // Final round passes the key-mixed state straight through
    always_comb begin
        if (last1_r) begin
            mixed_s = d1_r;
        end else begin
            mixed_s = mix_cols_s;
        end
    end

    // Stage 1: AddRoundKey register
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            d1_r    <= {W{1'b0}};
            last1_r <= 1'b0;
        end else if (load1_s) begin
            v1_r    <= 1'b1;
            d1_r    <= state_in ^ round_key;
            last1_r <= last_round;
        end else if (load2_s) begin
            v1_r    <= 1'b0;
        end else begin
            v1_r    <= v1_r;
        end
    end

    // Stage 2: InvMixColumns result register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r    <= 1'b0;
            d2_r    <= {W{1'b0}};
            last2_r <= 1'b0;
        end else if (load2_s) begin
            v2_r    <= 1'b1;
            d2_r    <= mixed_s;
            last2_r <= last1_r;
        end else if (out_ready) begin
            v2_r    <= 1'b0;
        end else begin
            v2_r    <= v2_r;
        end
    end

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// Directed + randomized bench for inv_addkey_mixcol against a matrix-based GF(2^8) reference model.
module tb_inv_addkey_mixcol;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, last_round, out_valid, out_ready, out_last;
    logic [127:0] state_in, round_key, state_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic         last;
    } tx_t;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    tx_t          tx_q[$];
    exp_t         exp_q[$];
    int           n_acc, n_out, run_len, max_run;
    logic         held_valid;
    logic [127:0] held_data;
    logic         held_last;

    inv_addkey_mixcol dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .round_key  (round_key),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Shift-and-add multiply followed by polynomial reduction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic exp_t model(input tx_t t);
        logic [7:0]   coef [4];
        logic [127:0] x;
        exp_t         e;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        x = t.data ^ t.key;
        e.last = t.last;
        e.data = x;
        if (!t.last) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    logic [7:0] acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gf_mul(coef[(k - r + 4) % 4], x[(4*c + k)*8 +: 8]);
                    e.data[(4*c + r)*8 +: 8] = acc;
                end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic tx_t rand_tx(input logic last);
        tx_t t;
        t.data = {$urandom, $urandom, $urandom, $urandom};
        t.key  = {$urandom, $urandom, $urandom, $urandom};
        t.last = last;
        return t;
    endfunction

    // One streaming cycle: drive at negedge, then score outputs and record accepts
    task automatic step(input logic ordy);
        exp_t e;
        @(negedge clk);
        out_ready = ordy;
        if (tx_q.size() > 0) begin
            in_valid = 1'b1; state_in = tx_q[0].data; round_key = tx_q[0].key; last_round = tx_q[0].last;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        if (held_valid) begin
            chk("stall_hold_data", state_out, held_data);
            chk("stall_hold_last", {127'd0, out_last}, {127'd0, held_last});
        end
        if (out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (out_valid && out_ready) begin
            held_valid = 1'b0;
            chk("no_spurious_out", {127'd0, exp_q.size() != 0}, 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stream_data", state_out, e.data);
                chk("stream_last", {127'd0, out_last}, {127'd0, e.last});
            end
            n_out++;
        end else if (out_valid) begin
            held_valid = 1'b1; held_data = state_out; held_last = out_last;
        end else begin
            held_valid = 1'b0;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(tx_q[0]));
            void'(tx_q.pop_front());
            n_acc++;
        end
    endtask

    // Single beat with an empty pipe: accept, then out_valid exactly two cycles later
    task automatic single(input string tag, input logic [127:0] d, input logic [127:0] k,
                          input logic l, input logic [127:0] exp_d);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; state_in = d; round_key = k; last_round = l;
        #1 chk({tag, "_accept"}, {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, "_lat1_valid"}, {127'd0, out_valid}, 128'd0);
        @(negedge clk);
        #1 chk({tag, "_lat2_valid"}, {127'd0, out_valid}, 128'd1);
        chk({tag, "_data"}, state_out, exp_d);
        chk({tag, "_last"}, {127'd0, out_last}, {127'd0, l});
    endtask

    task automatic drain(input string tag);
        int budget = 0;
        while ((exp_q.size() != 0 || tx_q.size() != 0) && budget < 50) begin
            step(1'b1);
            budget++;
        end
        chk({tag, "_drain_budget"}, {127'd0, budget < 50}, 128'd1);
    endtask

    initial begin
        int acc0, out0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; last_round = 1'b0;
        state_in = 128'd0; round_key = 128'd0;
        held_valid = 1'b0; n_acc = 0; n_out = 0; run_len = 0; max_run = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_state_out", state_out, 128'd0);
        chk("reset_out_last", {127'd0, out_last}, 128'd0);
        chk("reset_in_ready", {127'd0, in_ready}, 128'd1);

        single("known_col", {32'h01010101, 32'h01010101, 32'h01010101, 32'h9d58dc9f}, 128'd0, 1'b0,
               {32'h01010101, 32'h01010101, 32'h01010101, 32'h5c220af2});
        single("vec2", {32'h01010101, 32'h01010101, 32'hc6c6c6c6, 32'hbca14d8e}, 128'd0, 1'b0,
               {32'h01010101, 32'h01010101, 32'hc6c6c6c6, 32'h455313db});
        single("last_round", 128'hffeeddccbbaa99887766554433221100, {128{1'b1}}, 1'b1,
               128'h00112233445566778899aabbccddeeff);
        @(negedge clk);

        // Back-pressure: four beats offered with the consumer stalled for five cycles
        for (int i = 0; i < 4; i++) tx_q.push_back(rand_tx(1'($urandom_range(0, 1))));
        acc0 = n_acc; out0 = n_out; held_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (i >= 2) begin
                chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
                chk("bp_beat0_visible", state_out, exp_q[0].data);
            end
        end
        chk("bp_accept_count", 128'(n_acc - acc0), 128'd2);
        drain("bp");
        repeat (3) step(1'b1);
        chk("bp_out_count", 128'(n_out - out0), 128'd4);

        // Throughput: eight back-to-back beats with the consumer always ready
        for (int i = 0; i < 8; i++) tx_q.push_back(rand_tx(1'($urandom_range(0, 1))));
        acc0 = n_acc; out0 = n_out; max_run = 0; run_len = 0;
        repeat (8) step(1'b1);
        chk("tp_accept_count", 128'(n_acc - acc0), 128'd8);
        repeat (4) step(1'b1);
        chk("tp_out_count", 128'(n_out - out0), 128'd8);
        chk("tp_consecutive_valid", 128'(max_run), 128'd8);

        // Random mix of stalls and beats
        for (int i = 0; i < 20; i++) tx_q.push_back(rand_tx(1'($urandom_range(0, 1))));
        acc0 = n_acc; out0 = n_out;
        repeat (40) step(1'($urandom_range(0, 1)));
        drain("rand");
        chk("rand_out_count", 128'(n_out - out0), 128'(n_acc - acc0));

        // Reset with both stages full and a handshake offered in the same cycle
        for (int i = 0; i < 3; i++) tx_q.push_back(rand_tx(1'b1));
        repeat (3) step(1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        tx_q.delete(); exp_q.delete(); held_valid = 1'b0;
        #1;
        chk("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_mid_state_out", state_out, 128'd0);
        chk("rst_mid_out_last", {127'd0, out_last}, 128'd0);
        chk("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        #1 chk("rst_mid_no_ghost", {127'd0, out_valid}, 128'd0);
        begin
            tx_t  t;
            exp_t e;
            t = rand_tx(1'b0);
            e = model(t);
            single("post_reset", t.data, t.key, t.last, e.data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
